// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt controller beside the M stage.
// Holds SR, Cause and EPC. Raises req, the single pipeline flush/redirect
// strobe, when an enabled interrupt or a pending exception is seen outside
// exception level.
module cp0_unit #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret_in,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // Only the architecturally defined fields are stored.
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Request qualification: interrupts take priority over exceptions, and
    // exception level masks both.
    always_comb begin
        int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (exc_code_in != 5'd0) & ~sr_exl;
        req     = (int_req | exc_req) & ~reset;
    end

    // Register images with unimplemented bits reading zero.
    always_comb begin
        sr_word    = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
        cause_word = {cause_bd, 15'h0000, cause_ip, 3'b000, cause_exc, 2'b00};
    end

    // mfc0 read mux: pre-edge contents, no write-through.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_word;
            ADDR_CAUSE: cp0_rdata = cause_word;
            ADDR_EPC:   cp0_rdata = epc;
            default:    cp0_rdata = '0;
        endcase
    end

    assign epc_out = epc;

    // State update: exception entry overrides mtc0/eret; otherwise mtc0 is
    // applied and a same-edge eret then clears EXL (last assignment wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= int_req ? 5'd0 : exc_code_in;
                epc       <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (en && cp0_addr == ADDR_SR) begin
                    sr_im  <= cp0_wdata[15:10];
                    sr_exl <= cp0_wdata[1];
                    sr_ie  <= cp0_wdata[0];
                end
                if (en && cp0_addr == ADDR_EPC) begin
                    epc <= cp0_wdata;
                end
                if (eret_in) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenarios plus randomized cycles checked against a
// word-level reference model of SR/Cause/EPC.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret_in;
    logic        req;
    logic [31:0] epc_out;

    int errors = 0;
    int checks = 0;

    cp0_unit #(.EXC_ENTRY(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
        .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .eret_in(eret_in), .req(req), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick();
        en = 1'b0;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; en = 1'b0; cp0_addr = 5'd0; cp0_wdata = '0; vpc = '0;
        bd_in = 1'b0; exc_code_in = '0; hw_int = '0; eret_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        rd(5'd12, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h want %h", d, 32'h0); end
        rd(5'd13, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want %h", d, 32'h0); end
        rd(5'd14, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", d, 32'h0); end
        rd(5'd7, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_addr7: got %h want %h", d, 32'h0); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h want 0", epc_out); end
    endtask

    task automatic test_sr_mask();
        logic [31:0] d;
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, d); checks++; if (d !== 32'h0000_FC03) begin errors++; $display("FAIL sr_mask: got %h want %h", d, 32'h0000_FC03); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL cause_readonly: got %h want 0", d); end
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; vpc = 32'h0000_3010; bd_in = 1'b0;
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", req); end
        tick();
        rd(5'd12, d); checks++; if (d !== 32'h0000_0403) begin errors++; $display("FAIL int_sr: got %h want %h", d, 32'h0000_0403); end
        rd(5'd13, d); checks++; if (d !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h want %h", d, 32'h0000_0400); end
        rd(5'd14, d); checks++; if (d !== 32'h0000_3010) begin errors++; $display("FAIL int_epc: got %h want %h", d, 32'h0000_3010); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_masked_req: got %b want 0", req); end
        hw_int = '0; eret_in = 1'b1;
        tick();
        eret_in = 1'b0;
        rd(5'd12, d); checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL int_eret_sr: got %h want %h", d, 32'h0000_0401); end
    endtask

    task automatic test_exception_bd();
        logic [31:0] d;
        mtc0(5'd12, 32'h0);
        exc_code_in = 5'd4; vpc = 32'h0000_3020; bd_in = 1'b1;
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", req); end
        tick();
        exc_code_in = '0; bd_in = 1'b0;
        rd(5'd13, d); checks++; if (d !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h want %h", d, 32'h8000_0010); end
        rd(5'd14, d); checks++; if (d !== 32'h0000_301C) begin errors++; $display("FAIL exc_epc: got %h want %h", d, 32'h0000_301C); end
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_1001);
        exc_code_in = 5'd10; hw_int = 6'b000100; vpc = 32'h0000_3040; bd_in = 1'b0;
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", req); end
        tick();
        en = 1'b0; exc_code_in = '0;
        rd(5'd13, d); checks++; if (d !== 32'h0000_1000) begin errors++; $display("FAIL prio_cause: got %h want %h", d, 32'h0000_1000); end
        checks++; if (epc_out !== 32'h0000_3040) begin errors++; $display("FAIL prio_epc: got %h want %h", epc_out, 32'h0000_3040); end
        hw_int = '0;
    endtask

    task automatic test_nested_eret();
        logic [31:0] d;
        exc_code_in = 5'd12; vpc = 32'h0000_3050; bd_in = 1'b1;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL nested_req: got %b want 0", req); end
        tick();
        exc_code_in = '0; bd_in = 1'b0;
        checks++; if (epc_out !== 32'h0000_3040) begin errors++; $display("FAIL nested_epc: got %h want %h", epc_out, 32'h0000_3040); end
        rd(5'd13, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL nested_cause: got %h want 0", d); end
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;
        rd(5'd12, d); checks++; if (d !== 32'h0000_1001) begin errors++; $display("FAIL eret_sr: got %h want %h", d, 32'h0000_1001); end
        // mtc0 SR and eret on the same edge: write lands, then EXL clears
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF; eret_in = 1'b1;
        tick();
        en = 1'b0; eret_in = 1'b0;
        rd(5'd12, d); checks++; if (d !== 32'h0000_FC01) begin errors++; $display("FAIL mtc0_eret_sr: got %h want %h", d, 32'h0000_FC01); end
    endtask

    task automatic test_reset_mid_handler();
        logic [31:0] d;
        mtc0(5'd12, 32'h0);
        exc_code_in = 5'd5; vpc = 32'h0000_3060;
        tick();
        rd(5'd12, d); checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL handler_exl: got %h want %h", d, 32'h2); end
        reset = 1'b1;
        tick();
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", req); end
        reset = 1'b0; exc_code_in = '0;
        rd(5'd12, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_sr: got %h want 0", d); end
        rd(5'd13, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_cause: got %h want 0", d); end
        checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL midreset_epc: got %h want 0", epc_out); end
    endtask

    task automatic test_random();
        logic [31:0] m_sr, m_cause, m_epc, exp_rd;
        logic        m_int, m_exc, m_req;
        logic [4:0]  addrs [4];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd0;
        idle_inputs();
        reset = 1'b1;
        tick();
        m_sr = '0; m_cause = '0; m_epc = '0;
        for (int unsigned i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            en          = ($urandom_range(0, 3) == 0);
            cp0_addr    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 3)];
            cp0_wdata   = $urandom;
            vpc         = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            bd_in       = 1'($urandom);
            exc_code_in = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            hw_int      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            eret_in     = ($urandom_range(0, 5) == 0);
            #2;
            m_int = ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
            m_exc = (exc_code_in != 5'd0) && !m_sr[1];
            m_req = (m_int || m_exc) && !reset;
            case (cp0_addr)
                5'd12:   exp_rd = m_sr;
                5'd13:   exp_rd = m_cause;
                5'd14:   exp_rd = m_epc;
                default: exp_rd = 32'h0;
            endcase
            checks++; if (req !== m_req) begin errors++; $display("FAIL rand_req[%0d]: got %b want %b", i, req, m_req); end
            checks++; if (cp0_rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr %0d: got %h want %h", i, cp0_addr, cp0_rdata, exp_rd); end
            checks++; if (epc_out !== m_epc) begin errors++; $display("FAIL rand_epc_out[%0d]: got %h want %h", i, epc_out, m_epc); end
            @(posedge clk);
            if (reset) begin
                m_sr = '0; m_cause = '0; m_epc = '0;
            end else begin
                m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
                if (m_req) begin
                    m_sr    = m_sr | 32'h2;
                    m_cause = (32'(bd_in) << 31) | (32'(hw_int) << 10) | (32'(m_int ? 5'd0 : exc_code_in) << 2);
                    m_epc   = bd_in ? vpc - 32'd4 : vpc;
                end else begin
                    if (en && cp0_addr == 5'd12) m_sr = cp0_wdata & 32'h0000_FC03;
                    if (en && cp0_addr == 5'd14) m_epc = cp0_wdata;
                    if (eret_in) m_sr = m_sr & ~32'h2;
                end
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sr_mask();
        test_interrupt();
        test_exception_bd();
        test_priority();
        test_nested_eret();
        test_reset_mid_handler();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the M stage, takes the victim PC, the delay-slot flag, the accumulated exception code and the six external interrupt lines, and decides whether to raise `req`. `req` is the single flush/redirect signal consumed by every inter-stage pipeline register. The block also holds the SR, Cause and EPC registers for mfc0/mtc0/eret.

## Interface
- `EXC_ENTRY`, default 32'h0000_4180: handler entry address, exported for the fetch-side PC mux.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `en`  in  1  mtc0 write strobe, M stage.
- `cp0_addr`  in  5  register select: 12=SR, 13=Cause, 14=EPC.
- `cp0_wdata`  in  32  mtc0 write data.
- `cp0_rdata`  out  32  mfc0 read data, combinational.
- `vpc`  in  32  PC of the M-stage (victim) instruction.
- `bd_in`  in  1  the M-stage instruction is in a branch delay slot.
- `exc_code_in`  in  5  pending exception code of the M-stage instruction; 0 means none.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `eret_in`  in  1  the M-stage instruction is eret.
- `req`  out  1  exception/interrupt taken this cycle; flushes the pipeline.
- `epc_out`  out  32  current EPC register value.

## Operation
- SR fields: IM = [15:10], EXL = [1], IE = [0]. All other SR bits read 0.
- Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]. All other Cause bits read 0.
- EPC is a full 32-bit register.
- Any other address reads 0 and ignores writes.
- `int_req` = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
- `exc_req` = (exc_code_in != 0) & ~SR.EXL.
- `req` = (int_req | exc_req) & ~reset. It is combinational.
- Priority: an interrupt wins over a synchronous exception.
- On a clock edge with `req`=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode <= 0 if int_req, else exc_code_in.
  - EPC <= (bd_in ? vpc - 32'd4 : vpc), computed mod 2^32. vpc is word-aligned; EPC[1:0] follows vpc - 4.
  - A concurrent mtc0 (`en`) is discarded.
  - A concurrent eret is discarded.
- On a clock edge with `req`=0 and `eret_in`=1: SR.EXL <= 0.
  - If mtc0 to SR occurs in the same edge, the mtc0 value is written first, then EXL is cleared.
- On a clock edge with `req`=0 and `en`=1:
  - addr 12 writes only SR bits 15:10, 1 and 0 from cp0_wdata.
  - addr 14 writes EPC fully.
  - addr 13 is read-only; the write is ignored.
- Cause.IP <= hw_int on every non-reset edge, regardless of req, en and eret.
- `cp0_rdata` reflects register contents before the current edge. There is no write-through bypass.
- `epc_out` = EPC register. There is no bypass. The eret target is stable because mtc0→eret spacing is enforced by the stall unit.

## Timing
- Reset (edge with reset=1): SR, Cause and EPC all become 32'h0. Therefore:
  - req = 0.
  - cp0_rdata = 0 for all addresses.
  - epc_out = 0.
- While reset is high, `req` is held 0 combinationally, and no other updates occur.
- `req` asserts in the same cycle the qualifying condition appears. The register side effects land on the next rising edge.
- After a taken req, EXL=1 masks every further req, both interrupt and exception, until an eret retires.
- A nested exception while EXL=1 (e.g. a fault in the handler):
  - req stays 0.
  - EPC, Cause.BD and Cause.ExcCode are unchanged.
- hw_int pulses shorter than one cycle are not required to be captured.
- An interrupt is taken only while the line is held high at a sampling edge.
- Reset mid-handler (EXL=1): all state clears on that edge; execution restarts at 32'h0000_3000 via the pipeline registers.

## Test plan
- Reset, then read addrs 12/13/14/7 → all return 0; req=0; epc_out=0.
- mtc0 SR=32'hFFFF_FFFF, then read SR → 32'h0000_FC03.
- Set SR=32'h0000_0401, then hw_int=6'b000001, vpc=32'h0000_3010, bd_in=0 → req=1 in that cycle. Next cycle:
  - SR=32'h0000_0403.
  - Cause=32'h0000_0400.
  - EPC=32'h0000_3010.
  - req=0 while the line stays high.
- SR=0, exc_code_in=5'd4 (AdEL), vpc=32'h0000_3020, bd_in=1 → req=1. Next cycle:
  - Cause=32'h8000_0010.
  - EPC=32'h0000_301C.
- In the same cycle: exc_code_in=5'd10, hw_int[2]=1, SR=32'h0000_1001 → the interrupt wins: Cause.ExcCode=0 and EPC=vpc. A simultaneous mtc0 EPC=32'hDEAD_BEEF is dropped.
- With EXL=1, exc_code_in=5'd12 → req=0 and EPC unchanged. Then eret_in=1 → next cycle EXL=0. Then reassert reset mid-handler → all registers return to 0.
